// File: rtl/hilo_mult_unit_if.sv
// Command/result bundle between the pipeline and the HI/LO multiply unit.
// The pipeline side drives the command and reads status and HI/LO back.
interface hilo_mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alu_control, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, alu_control, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_mult_unit.sv
// Sequential shift-add multiplier that owns the MIPS-style HI/LO registers.
// A signed multiply works on operand magnitudes, and the sign is applied when
// the result is written back. mthi/mtlo write HI/LO directly when the unit is idle.
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  hilo_mult_unit_if.slave bus
);
  localparam logic [5:0] OP_MULT  = 6'b001111;
  localparam logic [5:0] OP_MULTU = 6'b010001;
  localparam logic [5:0] OP_MTHI  = 6'b111000;
  localparam logic [5:0] OP_MTLO  = 6'b111001;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               sign;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

  // Operand magnitudes for signed multiply; the most negative value maps to itself.
  always_comb begin
    mag_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    mag_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
  end

  // Control FSM plus datapath: accept commands in IDLE, one shift-add per RUN cycle, write back in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      sign   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.alu_control)
              OP_MULT: begin
                mcand  <= {{WIDTH{1'b0}}, mag_a};
                mplier <= mag_b;
                sign   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                acc    <= '0;
                count  <= '0;
                busy_r <= 1'b1;
                state  <= RUN;
              end
              OP_MULTU: begin
                mcand  <= {{WIDTH{1'b0}}, bus.a};
                mplier <= bus.b;
                sign   <= 1'b0;
                acc    <= '0;
                count  <= '0;
                busy_r <= 1'b1;
                state  <= RUN;
              end
              OP_MTHI: hi_r <= bus.a;
              OP_MTLO: lo_r <= bus.a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          // Busy drops as soon as the last step is taken so the pipeline sees
          // exactly WIDTH busy cycles; the write-back cycle follows.
          if (count == LAST_STEP) begin
            busy_r <= 1'b0;
            state  <= FIN;
          end
        end
        FIN: begin
          if (sign && (acc != '0)) begin
            {hi_r, lo_r} <= -acc;
          end else begin
            {hi_r, lo_r} <= acc;
          end
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
